integer_accumulator: RTL
========================

# integer_accumulator

Parametrised multi-channel integer accumulator used as a cocotb test DUT for integer and enum signal access at configurable widths and signedness. Samples arrive on a valid/ready stream tagged with a channel index and are summed per channel in wrap or saturate mode. A flush request drains every channel's sum in channel order over a second valid/ready stream. The FSM state is exposed as a sparse int-sized enum, and a 64-bit sample counter is provided.

## Interface

- WIDTH, 32, data and accumulator width in bits (2..64)
- SIGNED, 1, 1 = two's-complement arithmetic, 0 = unsigned
- SATURATE, 0, 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH
- CHANNELS, 4, number of accumulator channels (1..16)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sample valid
- in_ready  output  1  sample accepted when in_valid && in_ready
- in_channel  input  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are dropped
- in_data  input  WIDTH  sample value
- flush_req  input  1  single-cycle flush request
- out_valid  output  1  drained sum valid
- out_ready  input  1  drained sum consumed when out_valid && out_ready
- out_channel  output  max(1,$clog2(CHANNELS))  channel of out_data
- out_data  output  WIDTH  accumulated sum
- out_overflow  output  1  sticky overflow flag of out_channel
- state  output  32  FSM state as int enum: IDLE=0, ACCUM=1, FLUSH=45
- sample_count  output  64  accepted samples since reset

## Operation

- Reset (async assert, sync release): state=IDLE, all accumulators and overflow flags 0, flush index 0, sample_count 0, out_valid 0, out_channel 0, out_data 0, out_overflow 0, in_ready 0 while rst_n low.
- in_ready = 1 in IDLE and ACCUM, 0 in FLUSH.
- Accept: acc[ch] <= acc[ch] + in_data; sample_count += 1 (wraps at 2^64), including dropped out-of-range channels.
- Signed overflow: operands same sign, result sign differs. Unsigned overflow: carry out of bit WIDTH-1.
- On overflow: set ovf[ch] (sticky until drained). SATURATE=1: result = max (2^(W-1)-1 signed, 2^W-1 unsigned) or min (-2^(W-1)) per direction. SATURATE=0: wrapped result.
- FSM:
  - IDLE -> ACCUM on accepted sample.
  - IDLE or ACCUM -> FLUSH on flush_req; flush index reset to 0.
  - FLUSH -> IDLE on handshake with index CHANNELS-1.
  - flush_req in FLUSH ignored.
- FLUSH: out_valid=1, out_channel=index, out_data=acc[index], out_overflow=ovf[index]. On handshake, acc[index] and ovf[index] clear and the index increments. Outputs hold stable while out_ready=0.
- Outside FLUSH: out_valid=0, out_data and out_overflow 0.

## Timing

- Accumulate latency 1 cycle: sum visible internally on the edge after the accept.
- Simultaneous accept and flush_req in IDLE/ACCUM: the sample is included. FLUSH is entered on the next edge, and the first out_valid appears 1 cycle after flush_req.
- One channel is drained per cycle at most. With out_ready held high, a full drain takes CHANNELS cycles; state returns to IDLE on the edge of the last handshake.
- in_ready returns high the cycle after the last handshake.
- Reset mid-FLUSH: all sums lost, out_valid drops immediately (async), and no partial drain resumes.
- Flush of untouched channels emits 0 with out_overflow=0.

## Test plan

- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, state=0, sample_count=0, out_valid=0.
- WIDTH=8, SIGNED=1, SATURATE=0: ch0 += 100, 100 -> flush emits ch0 out_data=-56 (0xC8), out_overflow=1; ch1..3 emit 0, ovf 0; state sequence 0 -> 1 -> 45 -> 0.
- WIDTH=8, SIGNED=1, SATURATE=1: ch2 += -100, -100, 5 -> drained ch2 = -123 (clamps at -128, then +5), out_overflow=1; sample_count=3.
- WIDTH=8, SIGNED=0, SATURATE=1: ch1 += 200, 100 -> ch1 = 255, out_overflow=1.
- Back-pressure: flush with out_ready toggling 1/0 -> each channel emitted exactly once in order 0..CHANNELS-1, data stable while out_ready=0, in_ready=0 throughout FLUSH.
- Sample + flush_req in the same cycle, then rst_n pulsed during FLUSH -> sample appears in the drained sum before reset. After reset: state=0, all sums 0, second flush emits all zeros.

Source files
------------

// File: rtl/integer_accumulator.sv
// Multi-channel integer accumulator.
// Samples arrive on a valid/ready stream tagged with a channel index and are
// summed per channel, either wrapping or saturating on overflow. A flush request
// drains every channel's sum, lowest channel first, on a second valid/ready
// stream. The FSM state is exposed as a sparse 32-bit enum, and a 64-bit counter
// tracks accepted samples.
module integer_accumulator #(
  parameter int WIDTH    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0,
  parameter int CHANNELS = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_channel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_channel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow,
  output logic [31:0]      state,
  output logic [63:0]      sample_count
);

  typedef enum logic [31:0] {
    IDLE  = 32'd0,
    ACCUM = 32'd1,
    FLUSH = 32'd45
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  state_t             state_reg;
  logic [CW-1:0]      idx_reg;
  logic               in_ready_reg;
  logic [63:0]        count_reg;
  logic [WIDTH-1:0]   acc_reg [CHANNELS];
  logic [CHANNELS-1:0] ovf_reg;

  logic               accept;
  logic               drain;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] clr_hit;
  logic [WIDTH-1:0]   sel_acc;
  logic [WIDTH-1:0]   flush_acc;
  logic               flush_ovf;
  logic [WIDTH-1:0]   sum_wrap;
  logic [WIDTH-1:0]   sum_sat;
  logic               add_ovf;
  logic [WIDTH-1:0]   add_result;

  assign accept = in_valid && in_ready_reg;
  assign drain  = (state_reg == FLUSH) && out_ready;

  // Per-channel write and clear strobes; an out-of-range channel matches none.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
    assign wr_hit[gi]  = accept && (in_channel == CW'(gi));
    assign clr_hit[gi] = drain && (idx_reg == CW'(gi));
  end

  // Read the accumulator addressed by the incoming sample and the one being drained.
  always_comb begin
    sel_acc   = '0;
    flush_acc = '0;
    flush_ovf = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_channel == CW'(i)) begin
        sel_acc = acc_reg[i];
      end
      if (idx_reg == CW'(i)) begin
        flush_acc = acc_reg[i];
        flush_ovf = ovf_reg[i];
      end
    end
  end

  assign sum_wrap = sel_acc + in_data;

  if (SIGNED != 0) begin : g_signed
    // Overflow when both operands share a sign that the result does not.
    assign add_ovf = (sel_acc[WIDTH-1] == in_data[WIDTH-1]) &&
                     (sum_wrap[WIDTH-1] != sel_acc[WIDTH-1]);
    assign sum_sat = sel_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
  end else begin : g_unsigned
    // A carry out shows up as a wrapped sum smaller than an operand.
    assign add_ovf = (sum_wrap < sel_acc);
    assign sum_sat = '1;
  end

  assign add_result = (add_ovf && (SATURATE != 0)) ? sum_sat : sum_wrap;

  // Accumulator and sticky overflow storage: draining clears, accepting adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_reg[i] <= '0;
      end
      ovf_reg <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (clr_hit[i]) begin
          acc_reg[i] <= '0;
          ovf_reg[i] <= 1'b0;
        end else if (wr_hit[i]) begin
          acc_reg[i] <= add_result;
          if (add_ovf) begin
            ovf_reg[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Control FSM: tracks activity, walks the drain index and registers in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (flush_req) begin
            state_reg    <= FLUSH;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
          end else begin
            if (accept) begin
              state_reg <= ACCUM;
            end
            in_ready_reg <= 1'b1;
          end
        end
        FLUSH: begin
          in_ready_reg <= 1'b0;
          if (out_ready) begin
            if (idx_reg == LAST_IDX) begin
              state_reg    <= IDLE;
              idx_reg      <= '0;
              in_ready_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          idx_reg      <= '0;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Count every accepted sample, including those aimed at missing channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign in_ready     = in_ready_reg;
  assign state        = state_reg;
  assign sample_count = count_reg;
  assign out_valid    = (state_reg == FLUSH);
  assign out_channel  = idx_reg;
  assign out_data     = (state_reg == FLUSH) ? flush_acc : '0;
  assign out_overflow = (state_reg == FLUSH) && flush_ovf;

endmodule
